// File: rtl/aud_pkg.sv
// Shared types and constants for the audio record/playback controller.
// Key vector bit order used throughout: {stop, pause, play, rec}.
package aud_pkg;

  localparam logic [19:0] AUD_MAX_ADDR  = 20'hFFFFF;
  localparam logic [3:0]  AUD_MAX_SPEED = 4'd8;

  localparam int KEY_REC   = 0;
  localparam int KEY_PLAY  = 1;
  localparam int KEY_PAUSE = 2;
  localparam int KEY_STOP  = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REC        = 3'd1,
    ST_REC_PAUSE  = 3'd2,
    ST_PLAY       = 3'd3,
    ST_PLAY_PAUSE = 3'd4
  } aud_state_e;

  typedef enum logic [1:0] {
    MODE_NORMAL     = 2'b00,
    MODE_FAST       = 2'b01,
    MODE_SLOW_CONST = 2'b10,
    MODE_SLOW_LIN   = 2'b11
  } aud_mode_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_STOP,
    EV_PAUSE,
    EV_REC,
    EV_PLAY
  } aud_event_e;

  // Only the highest-priority key edge of a cycle survives.
  function automatic aud_event_e pick_event(input logic [3:0] rise);
    if (rise[KEY_STOP])       return EV_STOP;
    else if (rise[KEY_PAUSE]) return EV_PAUSE;
    else if (rise[KEY_REC])   return EV_REC;
    else if (rise[KEY_PLAY])  return EV_PLAY;
    else                      return EV_NONE;
  endfunction

  function automatic logic [3:0] sanitize_speed(input logic [3:0] raw);
    if (raw == 4'd0)               return 4'd1;
    else if (raw > AUD_MAX_SPEED)  return AUD_MAX_SPEED;
    else                           return raw;
  endfunction

endpackage

// File: rtl/aud_key_edge.sv
// Rising-edge detector for four debounced key levels. Edges are suppressed
// until one clock after reset release so keys held through reset stay silent.
module aud_key_edge (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_key,
  output logic [3:0] o_rise
);

  logic [3:0] prev_q, prev_d;
  logic       armed_q, armed_d;

  always_comb begin
    prev_d  = i_key;
    armed_d = 1'b1;
  end

  // NOTE: nonblocking assignments so every flop samples the pre-edge value of its _d.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q  <= 4'b0000;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign o_rise = armed_q ? (i_key & ~prev_q) : 4'b0000;

endmodule

// File: rtl/aud_ctrl.sv
// Record/playback control FSM driving a recorder, a DSP and a shared SRAM port.
// Optional macro AUD_PLAY_AUTOSTOP_EN: stop playback when i_dsp_addr wraps to 0.
module aud_ctrl
  import aud_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_key_rec,
  input  logic        i_key_play,
  input  logic        i_key_pause,
  input  logic        i_key_stop,
  input  logic [1:0]  i_mode,
  input  logic [3:0]  i_speed,
  input  logic [19:0] i_rec_addr,
  input  logic [19:0] i_dsp_addr,
  output logic        o_rec_start,
  output logic        o_rec_pause,
  output logic        o_rec_stop,
  output logic        o_dsp_start,
  output logic        o_dsp_pause,
  output logic        o_dsp_stop,
  output logic        o_fast,
  output logic        o_slow_0,
  output logic        o_slow_1,
  output logic [3:0]  o_speed,
  output logic [19:0] o_len,
  output logic [19:0] o_sram_addr,
  output logic        o_sram_we_n,
  output logic [2:0]  o_state
);

  logic [3:0] key_rise;
  aud_event_e ev;
  aud_mode_e  mode;
  logic       dsp_wrap;

  aud_state_e  state_q, state_d;
  logic        rec_start_q, rec_start_d;
  logic        rec_stop_q, rec_stop_d;
  logic        dsp_start_q, dsp_start_d;
  logic        dsp_stop_q, dsp_stop_d;
  logic        rec_pause_q, rec_pause_d;
  logic        dsp_pause_q, dsp_pause_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic [19:0] len_q, len_d;
  logic [3:0]  speed_q, speed_d;
  logic        fast_q, fast_d;
  logic        slow_0_q, slow_0_d;
  logic        slow_1_q, slow_1_d;

  aud_key_edge u_key_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_key   ({i_key_stop, i_key_pause, i_key_play, i_key_rec}),
    .o_rise  (key_rise)
  );

  assign ev   = pick_event(key_rise);
  assign mode = aud_mode_e'(i_mode);

`ifdef AUD_PLAY_AUTOSTOP_EN
  logic [19:0] dsp_prev_q, dsp_prev_d;

  always_comb dsp_prev_d = i_dsp_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) dsp_prev_q <= 20'd0;
    else          dsp_prev_q <= dsp_prev_d;
  end

  assign dsp_wrap = (dsp_prev_q != 20'd0) && (i_dsp_addr == 20'd0);
`else
  assign dsp_wrap = 1'b0;
`endif

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rec_start_d = 1'b0;
    rec_stop_d  = 1'b0;
    dsp_start_d = 1'b0;
    dsp_stop_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ev == EV_REC) begin
          state_d     = ST_REC;
          rec_start_d = 1'b1;
        end else if (ev == EV_PLAY && len_q != 20'd0) begin
          state_d     = ST_PLAY;
          dsp_start_d = 1'b1;
        end
      end
      ST_REC: begin
        // A full memory ends the take just like a stop key; i_rec_addr is then AUD_MAX_ADDR.
        if (ev == EV_STOP || i_rec_addr == AUD_MAX_ADDR) begin
          state_d    = ST_IDLE;
          rec_stop_d = 1'b1;
          len_d      = i_rec_addr;
        end else if (ev == EV_PAUSE) begin
          state_d = ST_REC_PAUSE;
        end
      end
      ST_REC_PAUSE: begin
        if (ev == EV_STOP) begin
          state_d    = ST_IDLE;
          rec_stop_d = 1'b1;
          len_d      = i_rec_addr;
        end else if (ev == EV_REC || ev == EV_PLAY) begin
          state_d = ST_REC;
        end
      end
      ST_PLAY: begin
        if (ev == EV_STOP || dsp_wrap) begin
          state_d    = ST_IDLE;
          dsp_stop_d = 1'b1;
        end else if (ev == EV_PAUSE) begin
          state_d = ST_PLAY_PAUSE;
        end
      end
      ST_PLAY_PAUSE: begin
        if (ev == EV_STOP) begin
          state_d    = ST_IDLE;
          dsp_stop_d = 1'b1;
        end else if (ev == EV_PLAY) begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Level outputs follow the next state so they line up with o_state.
    rec_pause_d = (state_d == ST_REC_PAUSE);
    dsp_pause_d = (state_d == ST_PLAY_PAUSE);
    sram_we_n_d = (state_d != ST_REC);

    speed_d  = sanitize_speed(i_speed);
    fast_d   = (speed_d != 4'd1) && (mode == MODE_FAST);
    slow_0_d = (speed_d != 4'd1) && (mode == MODE_SLOW_CONST);
    slow_1_d = (speed_d != 4'd1) && (mode == MODE_SLOW_LIN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      rec_start_q <= 1'b0;
      rec_stop_q  <= 1'b0;
      dsp_start_q <= 1'b0;
      dsp_stop_q  <= 1'b0;
      rec_pause_q <= 1'b0;
      dsp_pause_q <= 1'b0;
      sram_we_n_q <= 1'b1;
      len_q       <= 20'd0;
      speed_q     <= 4'd1;
      fast_q      <= 1'b0;
      slow_0_q    <= 1'b0;
      slow_1_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rec_start_q <= rec_start_d;
      rec_stop_q  <= rec_stop_d;
      dsp_start_q <= dsp_start_d;
      dsp_stop_q  <= dsp_stop_d;
      rec_pause_q <= rec_pause_d;
      dsp_pause_q <= dsp_pause_d;
      sram_we_n_q <= sram_we_n_d;
      len_q       <= len_d;
      speed_q     <= speed_d;
      fast_q      <= fast_d;
      slow_0_q    <= slow_0_d;
      slow_1_q    <= slow_1_d;
    end
  end

  assign o_rec_start = rec_start_q;
  assign o_rec_stop  = rec_stop_q;
  assign o_dsp_start = dsp_start_q;
  assign o_dsp_stop  = dsp_stop_q;
  assign o_rec_pause = rec_pause_q;
  assign o_dsp_pause = dsp_pause_q;
  assign o_sram_we_n = sram_we_n_q;
  assign o_len       = len_q;
  assign o_speed     = speed_q;
  assign o_fast      = fast_q;
  assign o_slow_0    = slow_0_q;
  assign o_slow_1    = slow_1_q;
  assign o_state     = state_q;

  assign o_sram_addr = (state_q == ST_REC || state_q == ST_REC_PAUSE) ? i_rec_addr : i_dsp_addr;

endmodule

// File: tb/tb_aud_ctrl.sv
// Self-checking bench for aud_ctrl: directed sequences, a speed/mode vector
// table, then randomized key traffic compared against a behavioural model.
module tb_aud_ctrl;
  import aud_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_key_rec, i_key_play, i_key_pause, i_key_stop;
  logic [1:0]  i_mode;
  logic [3:0]  i_speed;
  logic [19:0] i_rec_addr, i_dsp_addr;
  logic        o_rec_start, o_rec_pause, o_rec_stop;
  logic        o_dsp_start, o_dsp_pause, o_dsp_stop;
  logic        o_fast, o_slow_0, o_slow_1;
  logic [3:0]  o_speed;
  logic [19:0] o_len, o_sram_addr;
  logic        o_sram_we_n;
  logic [2:0]  o_state;

  always #5 i_clk = ~i_clk;

  aud_ctrl dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_key_rec   (i_key_rec),
    .i_key_play  (i_key_play),
    .i_key_pause (i_key_pause),
    .i_key_stop  (i_key_stop),
    .i_mode      (i_mode),
    .i_speed     (i_speed),
    .i_rec_addr  (i_rec_addr),
    .i_dsp_addr  (i_dsp_addr),
    .o_rec_start (o_rec_start),
    .o_rec_pause (o_rec_pause),
    .o_rec_stop  (o_rec_stop),
    .o_dsp_start (o_dsp_start),
    .o_dsp_pause (o_dsp_pause),
    .o_dsp_stop  (o_dsp_stop),
    .o_fast      (o_fast),
    .o_slow_0    (o_slow_0),
    .o_slow_1    (o_slow_1),
    .o_speed     (o_speed),
    .o_len       (o_len),
    .o_sram_addr (o_sram_addr),
    .o_sram_we_n (o_sram_we_n),
    .o_state     (o_state)
  );

`ifdef AUD_PLAY_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] spd;
    logic [1:0] mode;
    logic [3:0] e_spd;
    logic [2:0] e_sel;  // {fast, slow_0, slow_1}
  } vec_t;

  vec_t vecs[9];

  // Reference model state
  aud_state_e  m_state;
  logic [19:0] m_len, m_dsp_prev;
  logic [3:0]  m_prev_keys, m_speed;
  logic [2:0]  m_sel;
  logic        m_rec_start, m_rec_stop, m_dsp_start, m_dsp_stop;
  int          prio[4] = '{3, 2, 0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_keys(input logic [3:0] k);  // {stop, pause, play, rec}
    {i_key_stop, i_key_pause, i_key_play, i_key_rec} = k;
  endtask

  task automatic model_reset();
    m_state     = ST_IDLE;
    m_len       = 20'd0;
    m_dsp_prev  = 20'd0;
    m_prev_keys = 4'd0;
    m_speed     = 4'd1;
    m_sel       = 3'b000;
    m_rec_start = 1'b0;
    m_rec_stop  = 1'b0;
    m_dsp_start = 1'b0;
    m_dsp_stop  = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs held across it.
  task automatic model_step();
    logic [3:0] keys, rise;
    int win;
    logic wrap;
    keys = {i_key_stop, i_key_pause, i_key_play, i_key_rec};
    rise = keys & ~m_prev_keys;
    m_prev_keys = keys;
    win = -1;
    for (int i = 0; i < 4; i++)
      if (win < 0 && rise[prio[i]]) win = prio[i];
    wrap = AUTOSTOP && (m_dsp_prev != 20'd0) && (i_dsp_addr == 20'd0);
    m_dsp_prev = i_dsp_addr;
    m_rec_start = 1'b0; m_rec_stop = 1'b0; m_dsp_start = 1'b0; m_dsp_stop = 1'b0;
    case (m_state)
      ST_IDLE:
        if (win == 0) begin m_state = ST_REC; m_rec_start = 1'b1; end
        else if (win == 1 && m_len != 0) begin m_state = ST_PLAY; m_dsp_start = 1'b1; end
      ST_REC:
        if (win == 3 || i_rec_addr == 20'hFFFFF) begin
          m_state = ST_IDLE; m_rec_stop = 1'b1; m_len = i_rec_addr;
        end else if (win == 2) m_state = ST_REC_PAUSE;
      ST_REC_PAUSE:
        if (win == 3) begin m_state = ST_IDLE; m_rec_stop = 1'b1; m_len = i_rec_addr; end
        else if (win == 0 || win == 1) m_state = ST_REC;
      ST_PLAY:
        if (win == 3 || wrap) begin m_state = ST_IDLE; m_dsp_stop = 1'b1; end
        else if (win == 2) m_state = ST_PLAY_PAUSE;
      default:  // PLAY_PAUSE
        if (win == 3) begin m_state = ST_IDLE; m_dsp_stop = 1'b1; end
        else if (win == 1) m_state = ST_PLAY;
    endcase
    m_speed = (i_speed == 0) ? 4'd1 : (i_speed > 8) ? 4'd8 : i_speed;
    if (m_speed == 1) m_sel = 3'b000;
    else m_sel = (i_mode == 2'b01) ? 3'b100 : (i_mode == 2'b10) ? 3'b010 :
                 (i_mode == 2'b11) ? 3'b001 : 3'b000;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] kv;
    logic [16:0] act_ctrl, exp_ctrl;
    logic [19:0] exp_addr;
    int bad;

    vecs[0] = '{4'd0,  2'b11, 4'd1, 3'b000};
    vecs[1] = '{4'd12, 2'b11, 4'd8, 3'b001};
    vecs[2] = '{4'd1,  2'b01, 4'd1, 3'b000};
    vecs[3] = '{4'd2,  2'b01, 4'd2, 3'b100};
    vecs[4] = '{4'd8,  2'b10, 4'd8, 3'b010};
    vecs[5] = '{4'd9,  2'b00, 4'd8, 3'b000};
    vecs[6] = '{4'd15, 2'b10, 4'd8, 3'b010};
    vecs[7] = '{4'd5,  2'b11, 4'd5, 3'b001};
    vecs[8] = '{4'd7,  2'b00, 4'd7, 3'b000};

    set_keys(4'b0000);
    i_mode = 2'b00; i_speed = 4'd0; i_rec_addr = 20'd0; i_dsp_addr = 20'd0;
    i_rst_n = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    check("reset_state", 32'(o_state), 32'(ST_IDLE));
    check("reset_we_n", 32'(o_sram_we_n), 32'd1);
    check("reset_len", 32'(o_len), 32'd0);
    check("reset_speed", 32'(o_speed), 32'd1);
    check("reset_sel", 32'({o_fast, o_slow_0, o_slow_1}), 32'd0);
    check("reset_levels", 32'({o_rec_start, o_rec_stop, o_dsp_start, o_dsp_stop, o_rec_pause, o_dsp_pause}), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick(); tick();

    // Play with nothing recorded is refused
    set_keys(4'b0010); tick();
    check("play_len0_start", 32'(o_dsp_start), 32'd0);
    check("play_len0_state", 32'(o_state), 32'(ST_IDLE));
    set_keys(4'b0000); tick();

    for (int i = 0; i < 9; i++) begin
      i_speed = vecs[i].spd; i_mode = vecs[i].mode;
      tick();
      check($sformatf("vec%0d_speed", i), 32'(o_speed), 32'(vecs[i].e_spd));
      check($sformatf("vec%0d_sel", i), 32'({o_fast, o_slow_0, o_slow_1}), 32'(vecs[i].e_sel));
    end
    i_speed = 4'd3; i_mode = 2'b00;

    // Record 1000 addresses then stop
    i_rec_addr = 20'd0;
    set_keys(4'b0001); tick();
    check("rec_start_pulse", 32'(o_rec_start), 32'd1);
    check("rec_state", 32'(o_state), 32'(ST_REC));
    check("rec_we_n", 32'(o_sram_we_n), 32'd0);
    set_keys(4'b0000);
    bad = 0;
    for (int a = 0; a < 1000; a++) begin
      i_rec_addr = 20'(a);
      tick();
      if (o_sram_we_n !== 1'b0 || o_rec_start !== 1'b0 || o_sram_addr !== 20'(a)) bad++;
    end
    check("rec_ramp_bad_cycles", 32'(bad), 32'd0);
    set_keys(4'b1000); tick();
    check("rec_stop_pulse", 32'(o_rec_stop), 32'd1);
    check("rec_stop_len", 32'(o_len), 32'd999);
    check("rec_stop_state", 32'(o_state), 32'(ST_IDLE));
    check("rec_stop_we_n", 32'(o_sram_we_n), 32'd1);
    set_keys(4'b0000); tick();
    check("rec_stop_single", 32'(o_rec_stop), 32'd0);

    // Play now succeeds
    i_dsp_addr = 20'h12345;
    set_keys(4'b0010); tick();
    check("play_start_pulse", 32'(o_dsp_start), 32'd1);
    check("play_state", 32'(o_state), 32'(ST_PLAY));
    check("play_addr", 32'(o_sram_addr), 32'h12345);
    set_keys(4'b0000); i_dsp_addr = 20'h00ABC; #1;
    check("play_addr_comb", 32'(o_sram_addr), 32'h00ABC);
    tick();
    check("play_start_single", 32'(o_dsp_start), 32'd0);

    // Pause and stop together: stop wins
    set_keys(4'b1100); tick();
    check("ps_state", 32'(o_state), 32'(ST_IDLE));
    check("ps_dsp_stop", 32'(o_dsp_stop), 32'd1);
    check("ps_dsp_pause", 32'(o_dsp_pause), 32'd0);
    set_keys(4'b0000); tick();
    check("ps_dsp_stop_single", 32'(o_dsp_stop), 32'd0);
    check("ps_dsp_pause_after", 32'(o_dsp_pause), 32'd0);

    // Recording to the end of memory
    i_rec_addr = 20'd5;
    set_keys(4'b0001); tick();
    check("full_rec_state", 32'(o_state), 32'(ST_REC));
    check("full_len_kept", 32'(o_len), 32'd999);
    set_keys(4'b0000); i_rec_addr = 20'hFFFFE; tick();
    check("full_we_before", 32'(o_sram_we_n), 32'd0);
    i_rec_addr = 20'hFFFFF; tick();
    check("full_state", 32'(o_state), 32'(ST_IDLE));
    check("full_rec_stop", 32'(o_rec_stop), 32'd1);
    check("full_len", 32'(o_len), 32'hFFFFF);
    check("full_we_after", 32'(o_sram_we_n), 32'd1);

    // Reset mid-record, with the record key held through reset
    i_rec_addr = 20'd100;
    set_keys(4'b0001); tick();
    check("rst_rec_state", 32'(o_state), 32'(ST_REC));
    #3 i_rst_n = 1'b0;
    #1;
    check("rst_mid_we_n", 32'(o_sram_we_n), 32'd1);
    check("rst_mid_state", 32'(o_state), 32'(ST_IDLE));
    check("rst_mid_len", 32'(o_len), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick(); tick(); tick();
    check("held_key_state", 32'(o_state), 32'(ST_IDLE));
    check("held_key_start", 32'(o_rec_start), 32'd0);
    set_keys(4'b0000); tick();
    set_keys(4'b0001); tick();
    check("repress_start", 32'(o_rec_start), 32'd1);
    i_rec_addr = 20'd10;
    set_keys(4'b1000); tick();
    check("short_rec_len", 32'(o_len), 32'd10);
    set_keys(4'b0000); tick();

    // Address wrap during playback
    i_dsp_addr = 20'd999;
    set_keys(4'b0010); tick();
    check("wrap_play_state", 32'(o_state), 32'(ST_PLAY));
    set_keys(4'b0000); tick();
    i_dsp_addr = 20'd0; tick();
`ifdef AUD_PLAY_AUTOSTOP_EN
    check("wrap_autostop_pulse", 32'(o_dsp_stop), 32'd1);
    check("wrap_autostop_state", 32'(o_state), 32'(ST_IDLE));
`else
    check("wrap_loop_state", 32'(o_state), 32'(ST_PLAY));
    check("wrap_loop_no_stop", 32'(o_dsp_stop), 32'd0);
    set_keys(4'b1000); tick();
    set_keys(4'b0000); tick();
`endif

    // Randomized traffic against the model
    i_rst_n = 1'b0;
    i_speed = 4'd0; i_mode = 2'b00; i_rec_addr = 20'd0; i_dsp_addr = 20'd0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick(); tick();
    model_reset();
    kv = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 7) == 0) kv[k] = ~kv[k];
      set_keys(kv);
      i_mode     = 2'($urandom_range(0, 3));
      i_speed    = 4'($urandom_range(0, 15));
      i_rec_addr = 20'($urandom_range(0, 20'hFFFFE));
      i_dsp_addr = ($urandom_range(0, 15) == 0) ? 20'd0 : 20'($urandom_range(1, 20'hFFFFF));
      @(posedge i_clk);
      model_step();
      #1;
      act_ctrl = {o_state, o_rec_start, o_rec_stop, o_dsp_start, o_dsp_stop,
                  o_rec_pause, o_dsp_pause, o_sram_we_n, o_fast, o_slow_0, o_slow_1, o_speed};
      exp_ctrl = {3'(m_state), m_rec_start, m_rec_stop, m_dsp_start, m_dsp_stop,
                  m_state == ST_REC_PAUSE, m_state == ST_PLAY_PAUSE, m_state != ST_REC,
                  m_sel, m_speed};
      exp_addr = (m_state == ST_REC || m_state == ST_REC_PAUSE) ? i_rec_addr : i_dsp_addr;
      check("rand_ctrl", 32'(act_ctrl), 32'(exp_ctrl));
      check("rand_len", 32'(o_len), 32'(m_len));
      check("rand_addr", 32'(o_sram_addr), 32'(exp_addr));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aud_ctrl.md
AUD_CTRL -- requirements
Module: aud_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports i_clk and i_rst_n.
REQ-002 The block SHALL expose these ports (name  direction  width  meaning):
- i_clk  in  1  system clock
- i_rst_n  in  1  async active-low reset
- i_key_rec  in  1  debounced level key, record
- i_key_play  in  1  debounced level key, play/resume
- i_key_pause  in  1  debounced level key, pause
- i_key_stop  in  1  debounced level key, stop
- i_mode  in  2  00 normal, 01 fast, 10 slow constant, 11 slow linear
- i_speed  in  4  raw speed factor
- i_rec_addr  in  20  recorder current write address
- i_dsp_addr  in  20  DSP current read address
- o_rec_start / o_rec_pause / o_rec_stop  out  1 each  recorder controls
- o_dsp_start / o_dsp_pause / o_dsp_stop  out  1 each  DSP controls
- o_fast / o_slow_0 / o_slow_1  out  1 each  DSP mode select, one-hot or all zero
- o_speed  out  4  sanitized speed factor
- o_len  out  20  recorded length, last valid address
- o_sram_addr  out  20  muxed SRAM address
- o_sram_we_n  out  1  SRAM write enable, active low
- o_state  out  3  current state encoding

Function
REQ-003 Key events SHALL be rising edges of the i_key_* levels; each key acts once per press.
REQ-004 Event priority within one cycle SHALL be stop > pause > record > play; lower-priority events in the same cycle are discarded.
REQ-005 States SHALL be IDLE, REC, REC_PAUSE, PLAY and PLAY_PAUSE.
REQ-006 IDLE transitions:
- record -> REC, with a one-cycle o_rec_start pulse.
- play -> PLAY, with a one-cycle o_dsp_start pulse, only when o_len != 0; otherwise the block stays in IDLE.
REQ-007 REC transitions:
- pause -> REC_PAUSE.
- stop -> IDLE, o_rec_stop pulse, o_len <= i_rec_addr.
- i_rec_addr == 20'hFFFFF -> IDLE, o_rec_stop pulse, o_len <= 20'hFFFFF.
REQ-008 REC_PAUSE transitions:
- record or play -> REC.
- stop -> IDLE as in REQ-007.
REQ-009 PLAY transitions:
- pause -> PLAY_PAUSE.
- stop -> IDLE with an o_dsp_stop pulse.
- record -> ignored.
REQ-010 PLAY_PAUSE transitions:
- play -> PLAY.
- stop -> IDLE with an o_dsp_stop pulse.
REQ-011 o_rec_pause SHALL be 1 exactly in REC_PAUSE; o_dsp_pause SHALL be 1 exactly in PLAY_PAUSE; both are registered levels.
REQ-012 All start/stop outputs SHALL be registered single-cycle pulses, asserted the cycle after the key edge.
REQ-013 o_speed SHALL be 1 when i_speed == 0, 8 when i_speed > 8, and i_speed otherwise; the value is registered and updated every cycle.
REQ-014 When o_speed == 1, o_fast, o_slow_0 and o_slow_1 SHALL all be 0.
REQ-015 Otherwise, o_fast, o_slow_0 and o_slow_1 SHALL decode i_mode as one-hot.
REQ-016 i_mode 00 SHALL give all mode selects 0.
REQ-017 In REC and REC_PAUSE, o_sram_addr SHALL equal i_rec_addr; in all other states it SHALL equal i_dsp_addr. The mux is combinational.
REQ-018 o_sram_we_n SHALL be 0 only in REC and 1 in every other state, including on the transition cycle out of REC.
REQ-019 o_len SHALL change only on the record-stop events of REQ-007 and REQ-008.
REQ-020 A new record SHALL NOT clear o_len until that recording stops.

Reset
REQ-021 On i_rst_n low, the block SHALL immediately apply the following, regardless of current state:
- state = IDLE
- all pulses and pause levels = 0
- o_len = 0, o_speed = 1
- o_fast, o_slow_0, o_slow_1 = 0
- o_sram_we_n = 1
- key edge history = 0
REQ-022 Keys held high at reset release SHALL NOT generate events until released and pressed again.

Configuration
REQ-023 Macro AUD_PLAY_AUTOSTOP_EN: when defined, in PLAY the block SHALL detect i_dsp_addr wrapping from a nonzero value to 0 and then go to IDLE with an o_dsp_stop pulse.
REQ-024 When AUD_PLAY_AUTOSTOP_EN is undefined, playback SHALL loop until stopped.

Structure
REQ-025 Package aud_pkg SHALL hold:
- the state enum (3-bit)
- the mode enum (2-bit)
- AUD_MAX_ADDR = 20'hFFFFF
- AUD_MAX_SPEED = 8
REQ-026 Sub-module aud_key_edge SHALL provide 4-bit rising-edge detection, with async reset and a registered previous level.

Verification
REQ-027 Scenario: rec key, 1000 cycles with i_rec_addr ramping to 999, then stop key -> o_rec_start pulse, o_sram_we_n=0 during REC, o_rec_stop pulse, o_len=999, o_state=IDLE.
REQ-028 Scenario: play with o_len=0 -> no o_dsp_start, state stays IDLE; after REQ-027, play -> o_dsp_start pulse, o_sram_addr follows i_dsp_addr.
REQ-029 Scenario: pause and stop rising in the same cycle during PLAY -> IDLE with o_dsp_stop pulse; o_dsp_pause never asserted.
REQ-030 Scenario: i_speed=0 -> o_speed=1 and all mode selects 0; i_speed=12, i_mode=11 -> o_speed=8, o_slow_1=1.
REQ-031 Scenario: i_rec_addr reaches 20'hFFFFF in REC -> auto-stop, o_len=20'hFFFFF, o_sram_we_n=1 next cycle.
REQ-032 Scenario: reset asserted mid-REC -> immediately o_sram_we_n=1, state IDLE, o_len=0; with AUD_PLAY_AUTOSTOP_EN, i_dsp_addr going 999 -> 0 in PLAY -> o_dsp_stop pulse and IDLE.
